// File: rtl/convertidor_pkg.sv
// Shared types and constants for the serial double-dabble BCD converter:
// FSM state encoding, add-3 threshold and active-low 7-segment patterns.
package convertidor_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [3:0] BCD_ADD3_LIMIT = 4'd5;

  // Active-low, bit order gfedcba; codes 10..15 never occur and show blank.
  localparam logic [6:0] SEG7_LUT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b1111111, 7'b1111111,
    7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
  };

  function automatic logic [3:0] add3_digit(input logic [3:0] d);
    return (d >= BCD_ADD3_LIMIT) ? d + 4'd3 : d;
  endfunction

  function automatic longint unsigned pow10(input int n);
    longint unsigned r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

endpackage

// File: rtl/convertidor_bcd_serial_seg7.sv
// One BCD digit to active-low 7-segment pattern (gfedcba), used only
// when CONVERTIDOR_SEG7_EN is defined.
module decodificador_7seg
  import convertidor_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG7_LUT[bcd_i];

endmodule

// File: rtl/convertidor_bcd_serial.sv
// Serial double-dabble converter: magnitude + sign in, packed BCD + display sign out,
// one bit per clock. Optional 7-segment outputs with CONVERTIDOR_SEG7_EN.
module convertidor_bcd_serial
  import convertidor_pkg::*;
#(
  parameter int N      = 4,
  parameter int DIGITS = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [N-1:0]        mag,
  input  logic                neg,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*DIGITS-1:0] bcd,
  output logic                neg_out,
  output state_e              dbg_state
`ifdef CONVERTIDOR_SEG7_EN
  ,
  output logic [7*DIGITS-1:0] seg
`endif
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (pow10(DIGITS) <= ((64'd1 << N) - 64'd1)) begin : g_digits_check
    $error("convertidor_bcd_serial: DIGITS too small for N-bit magnitude");
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are
  // both high; in_ready only in IDLE, out_valid only in DONE, no buffering.
  state_e          state_q, state_d;
  logic [N-1:0]    sr_q, sr_d;
  logic [BW-1:0]   acc_q, acc_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BW-1:0]   bcd_q, bcd_d;
  logic            neg_out_q, neg_out_d;
  logic            neg_pend_q, neg_pend_d;
  logic [BW-1:0]   adj;

  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = (state_q == DONE);
  assign bcd       = bcd_q;
  assign neg_out   = neg_out_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    bcd_d      = bcd_q;
    neg_out_d  = neg_out_q;
    neg_pend_d = neg_pend_q;
    adj        = '0;
    for (int i = 0; i < DIGITS; i++) adj[4*i +: 4] = add3_digit(acc_q[4*i +: 4]);

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          state_d    = SHIFT;
          sr_d       = mag;
          neg_pend_d = neg && (mag != '0);
          acc_d      = '0;
          cnt_d      = '0;
        end
      end
      SHIFT: begin
        acc_d = {adj[BW-2:0], sr_q[N-1]};
        sr_d  = sr_q << 1;
        cnt_d = cnt_q + CW'(1);
        // The published result is the accumulator after this final shift.
        if (cnt_q == CW'(N - 1)) begin
          state_d   = DONE;
          bcd_d     = acc_d;
          neg_out_d = neg_pend_q;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sr_q       <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      bcd_q      <= '0;
      neg_out_q  <= 1'b0;
      neg_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      sr_q       <= sr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      bcd_q      <= bcd_d;
      neg_out_q  <= neg_out_d;
      neg_pend_q <= neg_pend_d;
    end
  end

`ifdef CONVERTIDOR_SEG7_EN
  for (genvar g = 0; g < DIGITS; g++) begin : g_seg
    decodificador_7seg u_dec (
      .bcd_i (bcd_q[4*g +: 4]),
      .seg_o (seg[7*g +: 7])
    );
  end
`endif

endmodule

// File: tb/tb_convertidor_bcd_serial.sv
// Directed bench for convertidor_bcd_serial: an N=4 instance for handshake,
// sign, backpressure and reset cases plus an N=7 instance swept over all inputs.
module tb_convertidor_bcd_serial;

  logic clk;
  logic rst;

  logic        a_in_valid, a_in_ready, a_neg, a_out_valid, a_out_ready, a_neg_out;
  logic [3:0]  a_mag;
  logic [7:0]  a_bcd;
  logic [1:0]  a_dbg;

  logic        b_in_valid, b_in_ready, b_neg, b_out_valid, b_out_ready, b_neg_out;
  logic [6:0]  b_mag;
  logic [11:0] b_bcd;
  logic [1:0]  b_dbg;

`ifdef CONVERTIDOR_SEG7_EN
  logic [13:0] a_seg;
  logic [20:0] b_seg;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] last_bcd = 8'h00;
  logic       last_neg = 1'b0;

  convertidor_bcd_serial #(.N(4), .DIGITS(2)) dut_a (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (a_in_valid),
    .in_ready  (a_in_ready),
    .mag       (a_mag),
    .neg       (a_neg),
    .out_valid (a_out_valid),
    .out_ready (a_out_ready),
    .bcd       (a_bcd),
    .neg_out   (a_neg_out),
    .dbg_state (a_dbg)
`ifdef CONVERTIDOR_SEG7_EN
    ,
    .seg       (a_seg)
`endif
  );

  convertidor_bcd_serial #(.N(7), .DIGITS(3)) dut_b (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (b_in_valid),
    .in_ready  (b_in_ready),
    .mag       (b_mag),
    .neg       (b_neg),
    .out_valid (b_out_valid),
    .out_ready (b_out_ready),
    .bcd       (b_bcd),
    .neg_out   (b_neg_out),
    .dbg_state (b_dbg)
`ifdef CONVERTIDOR_SEG7_EN
    ,
    .seg       (b_seg)
`endif
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One N=4 conversion with out_ready held high; inputs driven at negedge.
  task automatic conv_a(input logic [3:0] m, input logic n,
                        input logic [7:0] exp_bcd, input logic exp_neg);
    int lat;
    a_out_ready = 1'b1;
    check("a_ready_before", 32'(a_in_ready), 32'd1);
    a_mag = m; a_neg = n; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    check("a_busy_ready", 32'(a_in_ready), 32'd0);
    check("a_hold_bcd", 32'(a_bcd), 32'(last_bcd));
    check("a_hold_neg", 32'(a_neg_out), 32'(last_neg));
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("a_latency", 32'(lat), 32'd4);
    check("a_bcd", 32'(a_bcd), 32'(exp_bcd));
    check("a_neg_out", 32'(a_neg_out), 32'(exp_neg));
    @(negedge clk);
    check("a_back_idle", 32'(a_in_ready), 32'd1);
    check("a_ov_low", 32'(a_out_valid), 32'd0);
    check("a_bcd_kept", 32'(a_bcd), 32'(exp_bcd));
    last_bcd = exp_bcd;
    last_neg = exp_neg;
  endtask

  // One N=7 conversion checked against a decimal reference.
  task automatic conv_b(input int v);
    int lat;
    logic [11:0] exp_bcd;
    exp_bcd = {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    b_mag = 7'(v); b_neg = 1'b0; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (!b_out_valid && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    if (v == 127 || v == 0) check("b_latency", 32'(lat), 32'd7);
    check("b_bcd", 32'(b_bcd), 32'(exp_bcd));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int seen;
    rst = 1'b1;
    a_in_valid = 1'b0; a_mag = '0; a_neg = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_mag = '0; b_neg = 1'b0; b_out_ready = 1'b1;

    // Reset held for two cycles
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_bcd", 32'(a_bcd), 32'h00);
    check("rst_neg_out", 32'(a_neg_out), 32'd0);
    check("rst_in_ready", 32'(a_in_ready), 32'd0);
`ifdef CONVERTIDOR_SEG7_EN
    check("rst_seg", 32'(a_seg), 32'({7'b1000000, 7'b1000000}));
`endif
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready_a", 32'(a_in_ready), 32'd1);
    check("post_rst_ready_b", 32'(b_in_ready), 32'd1);

    // Basic conversions, sign handling and negative zero
    conv_a(4'b0111, 1'b0, 8'h07, 1'b0);
    conv_a(4'b1000, 1'b1, 8'h08, 1'b1);
`ifdef CONVERTIDOR_SEG7_EN
    check("seg_d0_eight", 32'(a_seg[6:0]), 32'(7'b0000000));
    check("seg_d1_zero", 32'(a_seg[13:7]), 32'(7'b1000000));
`endif
    conv_a(4'b0000, 1'b1, 8'h00, 1'b0);
    conv_a(4'b1111, 1'b0, 8'h15, 1'b0);
    conv_a(4'b1100, 1'b1, 8'h12, 1'b1);

    // Full sweep on the wider instance
    for (int v = 0; v < 128; v++) conv_b(v);
    check("b_neg_out_zero", 32'(b_neg_out), 32'd0);

    // Backpressure with a competing input waiting
    a_out_ready = 1'b0;
    a_mag = 4'd5; a_neg = 1'b0; a_in_valid = 1'b1;
    @(negedge clk);
    a_mag = 4'd9; a_neg = 1'b1;
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp_latency", 32'(lat), 32'd4);
    for (int i = 0; i < 3; i++) begin
      check("bp_out_valid", 32'(a_out_valid), 32'd1);
      check("bp_bcd", 32'(a_bcd), 32'h05);
      check("bp_neg_out", 32'(a_neg_out), 32'd0);
      check("bp_in_ready", 32'(a_in_ready), 32'd0);
      @(negedge clk);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_idle_after_hs", 32'(a_in_ready), 32'd1);
    check("bp_ov_after_hs", 32'(a_out_valid), 32'd0);
    @(negedge clk);
    a_in_valid = 1'b0;
    check("bp_accepted_state", 32'(a_dbg), 32'd1);
    lat = 0;
    while (!a_out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("bp2_latency", 32'(lat), 32'd4);
    check("bp2_bcd", 32'(a_bcd), 32'h09);
    check("bp2_neg_out", 32'(a_neg_out), 32'd1);
    @(negedge clk);

    // Reset during the second SHIFT cycle discards the conversion
    a_mag = 4'b0110; a_neg = 1'b0; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_state", 32'(a_dbg), 32'd0);
    check("mid_rst_out_valid", 32'(a_out_valid), 32'd0);
    check("mid_rst_bcd", 32'(a_bcd), 32'h00);
    check("mid_rst_neg_out", 32'(a_neg_out), 32'd0);
    check("mid_rst_in_ready", 32'(a_in_ready), 32'd0);
`ifdef CONVERTIDOR_SEG7_EN
    check("mid_rst_seg_d0", 32'(a_seg[6:0]), 32'(7'b1000000));
`endif
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (a_out_valid) seen++;
    end
    check("mid_rst_no_result", 32'(seen), 32'd0);
    check("mid_rst_idle_ready", 32'(a_in_ready), 32'd1);
    last_bcd = 8'h00;
    last_neg = 1'b0;
    conv_a(4'b1001, 1'b0, 8'h09, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
